i2c_target: RTL and testbench

I2C target (slave) responder for the SoC's I2C subsystem: the far end of the bus from the I2C master and its SCL clock generator. It oversamples SCL/SDA on the system clock and detects START/STOP conditions. It matches a 7-bit address and acknowledges it, then shifts write bytes out to a local consumer or shifts read bytes in from a local producer. SDA is open-drain; the block only ever pulls it low. Clock stretching is not supported.

---
 rtl/i2c_target.sv | 198 +++++++++++++++++++
 tb/tb_i2c_target.sv | 306 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/i2c_target.sv
// I2C target responder: oversampled SCL/SDA, START/STOP detection, 7-bit address match,
// byte receive to a local consumer and byte transmit from a local producer over open-drain SDA.
module i2c_target #(
    parameter logic [6:0] ADDR = 7'h50
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       scl_in,
    input  logic       sda_in,
    output logic       sda_oe,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    output logic       rx_first,
    output logic       tx_req,
    input  logic [7:0] tx_data,
    output logic       busy
);

    typedef enum logic [2:0] {
        S_IDLE, S_ADDR, S_ADDR_ACK, S_RX_BYTE, S_RX_ACK, S_TX_BYTE, S_TX_ACK, S_IGNORE
    } state_t;

    // Synchronizers are left out of reset so releasing reset never fabricates a bus edge.
    logic [1:0] scl_sync, sda_sync;
    logic       scl_hist, sda_hist;
    logic       scl_rise, scl_fall, start_det, stop_det;

    always_ff @(posedge clock) begin
        scl_sync <= {scl_sync[0], scl_in};
        sda_sync <= {sda_sync[0], sda_in};
        scl_hist <= scl_sync[1];
        sda_hist <= sda_sync[1];
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            scl_rise  <= 1'b0;
            scl_fall  <= 1'b0;
            start_det <= 1'b0;
            stop_det  <= 1'b0;
        end else begin
            scl_rise  <= scl_sync[1] & ~scl_hist;
            scl_fall  <= ~scl_sync[1] & scl_hist;
            start_det <= scl_sync[1] & scl_hist & ~sda_sync[1] & sda_hist;
            stop_det  <= scl_sync[1] & scl_hist & sda_sync[1] & ~sda_hist;
        end
    end

    state_t     state, state_n;
    logic [2:0] bit_cnt, bit_cnt_n;
    logic [7:0] shift, shift_n;
    logic [7:0] rx_data_n;
    logic       rw, rw_n, full, full_n;
    logic       sda_oe_n, rx_valid_n, rx_first_n, tx_req_n;

    always_ff @(posedge clock) begin
        if (reset) begin
            state    <= S_IDLE;
            bit_cnt  <= '0;
            shift    <= '0;
            rw       <= 1'b0;
            full     <= 1'b0;
            sda_oe   <= 1'b0;
            rx_data  <= '0;
            rx_valid <= 1'b0;
            rx_first <= 1'b0;
            tx_req   <= 1'b0;
        end else begin
            state    <= state_n;
            bit_cnt  <= bit_cnt_n;
            shift    <= shift_n;
            rw       <= rw_n;
            full     <= full_n;
            sda_oe   <= sda_oe_n;
            rx_data  <= rx_data_n;
            rx_valid <= rx_valid_n;
            rx_first <= rx_first_n;
            tx_req   <= tx_req_n;
        end
    end

    // sda_hist is the SDA level aligned with the registered SCL strobes.
    always_comb begin
        state_n    = state;
        bit_cnt_n  = bit_cnt;
        shift_n    = shift;
        rw_n       = rw;
        full_n     = full;
        sda_oe_n   = sda_oe;
        rx_data_n  = rx_data;
        rx_valid_n = 1'b0;
        rx_first_n = rx_first;
        tx_req_n   = 1'b0;
        if (start_det) begin
            state_n   = S_ADDR;
            sda_oe_n  = 1'b0;
            bit_cnt_n = '0;
            full_n    = 1'b0;
        end else if (stop_det) begin
            state_n  = S_IDLE;
            sda_oe_n = 1'b0;
            full_n   = 1'b0;
        end else begin
            case (state)
                S_ADDR: begin
                    if (scl_rise) begin
                        shift_n   = {shift[6:0], sda_hist};
                        bit_cnt_n = bit_cnt + 3'd1;
                        if (bit_cnt == 3'd7) full_n = 1'b1;
                    end else if (scl_fall && full) begin
                        full_n = 1'b0;
                        if (shift[7:1] == ADDR) begin
                            sda_oe_n = 1'b1;
                            rw_n     = shift[0];
                            tx_req_n = shift[0];
                            state_n  = S_ADDR_ACK;
                        end else begin
                            state_n = S_IGNORE;
                        end
                    end
                end
                S_ADDR_ACK: begin
                    if (scl_fall) begin
                        bit_cnt_n = '0;
                        if (rw) begin
                            shift_n  = tx_data;
                            sda_oe_n = ~tx_data[7];
                            state_n  = S_TX_BYTE;
                        end else begin
                            sda_oe_n   = 1'b0;
                            rx_first_n = 1'b1;
                            state_n    = S_RX_BYTE;
                        end
                    end
                end
                S_RX_BYTE: begin
                    if (scl_rise) begin
                        shift_n   = {shift[6:0], sda_hist};
                        bit_cnt_n = bit_cnt + 3'd1;
                        if (bit_cnt == 3'd7) begin
                            rx_data_n  = {shift[6:0], sda_hist};
                            rx_valid_n = 1'b1;
                            full_n     = 1'b1;
                        end
                    end else if (scl_fall && full) begin
                        full_n   = 1'b0;
                        sda_oe_n = 1'b1;
                        state_n  = S_RX_ACK;
                    end
                end
                S_RX_ACK: begin
                    if (scl_fall) begin
                        sda_oe_n   = 1'b0;
                        rx_first_n = 1'b0;
                        bit_cnt_n  = '0;
                        state_n    = S_RX_BYTE;
                    end
                end
                S_TX_BYTE: begin
                    if (scl_fall) begin
                        bit_cnt_n = bit_cnt + 3'd1;
                        if (bit_cnt == 3'd7) begin
                            sda_oe_n = 1'b0;
                            tx_req_n = 1'b1;
                            state_n  = S_TX_ACK;
                        end else begin
                            shift_n  = {shift[6:0], 1'b0};
                            sda_oe_n = ~shift[6];
                        end
                    end
                end
                S_TX_ACK: begin
                    if (scl_rise) begin
                        if (sda_hist) state_n = S_IGNORE;
                        else          full_n  = 1'b1;
                    end else if (scl_fall && full) begin
                        full_n    = 1'b0;
                        shift_n   = tx_data;
                        sda_oe_n  = ~tx_data[7];
                        bit_cnt_n = '0;
                        state_n   = S_TX_BYTE;
                    end
                end
                S_IDLE, S_IGNORE: ;
                default: state_n = S_IDLE;
            endcase
        end
    end

    always_comb begin
        busy = 1'b0;
        case (state)
            S_ADDR_ACK, S_RX_BYTE, S_RX_ACK, S_TX_BYTE, S_TX_ACK: busy = 1'b1;
            default: busy = 1'b0;
        endcase
    end

endmodule

// File: tb/tb_i2c_target.sv
// Bench for i2c_target: bit-banged bus master, transaction-level expectations pushed into
// queues, and independent monitors that pop and compare whenever the target responds.
module tb_i2c_target;

    localparam logic [6:0] TARGET = 7'h50;

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic       m_scl = 1'b1;
    logic       m_sda = 1'b1;
    logic [7:0] tx_data = 8'h00;
    logic       sda_bus;
    logic       sda_oe, rx_valid, rx_first, tx_req, busy;
    logic [7:0] rx_data;

    int checks = 0;
    int failures = 0;

    logic [8:0] exp_rx[$];   // {first, data}
    logic [7:0] tx_src[$];   // producer bytes handed out on tx_req
    int         exp_tx[$];   // one token per expected tx_req pulse
    logic       exp_bus[$];  // bus level the target must present at an SCL rise
    bit         listen = 1'b0;
    logic       prev_oe = 1'b0;
    logic [8:0] e_rx;

    assign sda_bus = m_sda & ~sda_oe;

    always #5 clock = ~clock;

    i2c_target #(.ADDR(TARGET)) dut (
        .clock    (clock),
        .reset    (reset),
        .scl_in   (m_scl),
        .sda_in   (sda_bus),
        .sda_oe   (sda_oe),
        .rx_data  (rx_data),
        .rx_valid (rx_valid),
        .rx_first (rx_first),
        .tx_req   (tx_req),
        .tx_data  (tx_data),
        .busy     (busy)
    );

    task automatic check1(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%b required=%b", name, act, exp);
        end
    endtask

    task automatic check8(input string name, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%02h required=%02h", name, act, exp);
        end
    endtask

    task automatic checki(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0d", name, act, exp);
        end
    endtask

    function automatic bit hits(input logic [7:0] a);
        return a[7:1] == TARGET;
    endfunction

    task automatic clk(input int n);
        repeat (n) @(negedge clock);
    endtask

    // SCL bit period is 40 system clocks; SDA only moves 6 clocks into the low phase.
    task automatic bus_start(input bit rep);
        if (rep) begin
            clk(6);
            m_sda = 1'b1;
            clk(14);
            check1("sr_release", sda_oe, 1'b0);
            m_scl = 1'b1;
            clk(20);
        end else begin
            m_scl = 1'b1;
            m_sda = 1'b1;
            clk(20);
        end
        m_sda = 1'b0;
        clk(20);
        m_scl = 1'b0;
    endtask

    task automatic bus_stop();
        clk(6);
        m_sda = 1'b0;
        clk(14);
        m_scl = 1'b1;
        clk(20);
        m_sda = 1'b1;
        clk(20);
    endtask

    task automatic put_bit(input logic b);
        clk(6);
        m_sda = b;
        clk(14);
        m_scl = 1'b1;
        clk(20);
        m_scl = 1'b0;
    endtask

    task automatic get_bit(input logic exp);
        clk(6);
        m_sda = 1'b1;
        exp_bus.push_back(exp);
        clk(14);
        listen = 1'b1;
        m_scl = 1'b1;
        clk(20);
        m_scl = 1'b0;
        listen = 1'b0;
    endtask

    task automatic put_byte(input logic [7:0] b);
        for (int i = 7; i >= 0; i--) put_bit(b[i]);
    endtask

    task automatic xfer_write(input logic [7:0] a, input logic [7:0] d[$], input bit rep, input bit stop);
        bit hit;
        hit = hits(a);
        bus_start(rep);
        put_byte(a);
        get_bit(!hit);
        foreach (d[i]) begin
            if (hit) exp_rx.push_back({i == 0, d[i]});
            put_byte(d[i]);
            get_bit(!hit);
        end
        clk(6);
        check1("busy_addressed", busy, hit);
        if (stop) begin
            bus_stop();
            check1("busy_after_stop", busy, 1'b0);
        end
    endtask

    task automatic xfer_read(input logic [7:0] a, input logic [7:0] d[$], input bit rep);
        bit hit;
        hit = hits(a);
        bus_start(rep);
        if (hit) begin
            exp_tx.push_back(0);
            foreach (d[i]) tx_src.push_back(d[i]);
        end
        put_byte(a);
        get_bit(!hit);
        if (hit) begin
            foreach (d[i]) begin
                logic [7:0] cur;
                cur = d[i];
                exp_tx.push_back(i + 1);
                for (int b = 7; b >= 0; b--) get_bit(cur[b]);
                put_bit(i == d.size() - 1);
            end
        end
        clk(6);
        check1("busy_after_read", busy, 1'b0);
        bus_stop();
    endtask

    always @(posedge m_scl) begin
        #1;
        if (listen) begin
            checki("sda_slot_expected", exp_bus.size() > 0, 1);
            if (exp_bus.size() > 0) check1("sda_bit", sda_bus, exp_bus.pop_front());
        end
    end

    always @(negedge clock) begin
        if (rx_valid) begin
            checki("rx_valid_expected", exp_rx.size() > 0, 1);
            if (exp_rx.size() > 0) begin
                e_rx = exp_rx.pop_front();
                check8("rx_data", rx_data, e_rx[7:0]);
                check1("rx_first", rx_first, e_rx[8]);
            end
        end
        if (tx_req) begin
            checki("tx_req_expected", exp_tx.size() > 0, 1);
            if (exp_tx.size() > 0) void'(exp_tx.pop_front());
            if (tx_src.size() > 0) tx_data = tx_src.pop_front();
        end
        if (sda_oe !== prev_oe) check1("oe_change_scl_low", m_scl, 1'b0);
        prev_oe = sda_oe;
    end

    task automatic check_reset_values(input string tag);
        check1({tag, "_sda_oe"}, sda_oe, 1'b0);
        check8({tag, "_rx_data"}, rx_data, 8'h00);
        check1({tag, "_rx_valid"}, rx_valid, 1'b0);
        check1({tag, "_rx_first"}, rx_first, 1'b0);
        check1({tag, "_tx_req"}, tx_req, 1'b0);
        check1({tag, "_busy"}, busy, 1'b0);
    endtask

    initial begin
        logic [7:0] q[$];
        logic [7:0] a;
        logic [7:0] rb;
        int n;

        clk(5);
        check_reset_values("reset");
        reset = 1'b0;
        clk(5);

        q = {};
        q.push_back(8'hA5);
        q.push_back(8'h3C);
        xfer_write(8'hA0, q, 1'b0, 1'b1);

        q = {};
        q.push_back(8'h55);
        xfer_write(8'hA2, q, 1'b0, 1'b1);

        q = {};
        q.push_back(8'hC3);
        q.push_back(8'h5A);
        xfer_read(8'hA1, q, 1'b0);

        q = {};
        q.push_back(8'h01);
        xfer_write(8'hA0, q, 1'b0, 1'b0);
        q = {};
        q.push_back(8'h96);
        xfer_read(8'hA1, q, 1'b1);

        // STOP four bits into a data byte, then a normal write.
        bus_start(1'b0);
        put_byte(8'hA0);
        get_bit(1'b0);
        for (int i = 0; i < 4; i++) put_bit(i[0]);
        bus_stop();
        check1("busy_after_abort", busy, 1'b0);
        q = {};
        q.push_back(8'h6E);
        xfer_write(8'hA0, q, 1'b0, 1'b1);

        q = {};
        q.push_back(8'h12);
        xfer_write(8'h00, q, 1'b0, 1'b1);

        for (int t = 0; t < 10; t++) begin
            case ($urandom_range(0, 4))
                0: a = 8'hA0;
                1: a = 8'hA1;
                2: a = 8'($urandom_range(0, 255));
                3: a = 8'hA3;
                default: a = 8'h00;
            endcase
            q = {};
            n = a[0] ? int'($urandom_range(1, 3)) : int'($urandom_range(0, 3));
            for (int i = 0; i < n; i++) q.push_back(8'($urandom()));
            if (a[0]) xfer_read(a, q, 1'b0);
            else      xfer_write(a, q, 1'b0, 1'b1);
        end

        // Reset while the target pulls SDA low for read bit 0.
        rb = 8'hC2;
        bus_start(1'b0);
        exp_tx.push_back(0);
        tx_src.push_back(rb);
        put_byte(8'hA1);
        get_bit(1'b0);
        for (int b = 7; b >= 1; b--) get_bit(rb[b]);
        clk(8);
        check1("oe_before_reset", sda_oe, 1'b1);
        reset = 1'b1;
        clk(1);
        check_reset_values("midreset");
        clk(3);
        reset = 1'b0;
        clk(3);
        put_byte(8'hA0);
        get_bit(1'b1);
        clk(6);
        check1("busy_no_start", busy, 1'b0);
        bus_stop();
        q = {};
        q.push_back(8'h77);
        xfer_write(8'hA0, q, 1'b0, 1'b1);

        clk(50);
        checki("rx_queue_drained", exp_rx.size(), 0);
        checki("tx_queue_drained", exp_tx.size(), 0);
        checki("bus_queue_drained", exp_bus.size(), 0);
        checki("tx_src_drained", tx_src.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
